// File: rtl/frc_pkg.sv
// Shared types and constants for the function request controller.
package frc_pkg;
    localparam int FUNC_W = 2;
    localparam logic [FUNC_W-1:0] FUNC2_CODE = 2'd2;
    localparam logic [FUNC_W-1:0] FUNC_NONE  = 2'd0;
    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int NUM_IF = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } if_state_e;
endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer, stable-count debouncer and rising-edge press pulse for one button.
module button_debouncer
    import frc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic       sync1, sync2, db, db_q, armed;
    logic [1:0] vld_pipe;
    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            db       <= 1'b0;
            db_q     <= 1'b0;
            armed    <= 1'b0;
            vld_pipe <= '0;
            cnt      <= '0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            vld_pipe <= {vld_pipe[0], 1'b1};
            db_q     <= db;
            // Presses count only after a genuine low has been seen, so a button held through reset stays quiet.
            if (vld_pipe[1] && !sync2 && !db)
                armed <= 1'b1;
            if (sync2 != db) begin
                if (cnt == CNT_LAST) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign press = db & ~db_q & armed;
endmodule

// File: rtl/function_request_controller.sv
// Two-interface request controller: per-interface IDLE/ACTIVE FSMs, display ownership and priority toggle.
module function_request_controller
    import frc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ie01_btn,
    input  logic              ie02_btn,
    input  logic [FUNC_W-1:0] ie01_func,
    input  logic [FUNC_W-1:0] ie02_func,
    input  logic              done,
    output logic              ie01_active,
    output logic              ie02_active,
    output logic [FUNC_W-1:0] ie01_code,
    output logic [FUNC_W-1:0] ie02_code,
    output logic              A,
    output logic              B,
    output logic              priorsel
);
    logic [NUM_IF-1:0]             btn, press, own, f2, act;
    logic [NUM_IF-1:0][FUNC_W-1:0] func, code;
    if_state_e                     state [NUM_IF];

    assign btn  = {ie02_btn, ie01_btn};
    assign func = {ie02_func, ie01_func};

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_IF-1:0] (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn),
        .press (press)
    );

    for (genvar g = 0; g < NUM_IF; g++) begin : g_dec
        assign act[g] = (state[g] == ACTIVE);
        assign f2[g]  = act[g] && (code[g] == FUNC2_CODE);
    end

    // Function-2 requests win; priorsel breaks the tie, then IE01 beats IE02.
    assign own[0] = f2[0] ? (!priorsel || !f2[1]) : (!f2[1] && act[0]);
    assign own[1] = act[1] && !own[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_IF; i++) begin
                state[i] <= IDLE;
                code[i]  <= FUNC_NONE;
            end
            priorsel <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_IF; i++) begin
                if (done && own[i]) begin
                    state[i] <= IDLE;
                    code[i]  <= FUNC_NONE;
                end else if (press[i]) begin
                    if (state[i] == IDLE) begin
                        state[i] <= ACTIVE;
                        code[i]  <= func[i];
                    end else begin
                        state[i] <= IDLE;
                        code[i]  <= FUNC_NONE;
                    end
                end
            end
            if (done && f2[0] && f2[1])
                priorsel <= ~priorsel;
        end
    end

    assign ie01_active = act[0];
    assign ie02_active = act[1];
    assign ie01_code   = code[0];
    assign ie02_code   = code[1];
    assign A           = f2[0];
    assign B           = f2[1];
endmodule

// File: tb/tb_function_request_controller.sv
// Directed plus randomized bench for function_request_controller against a history-based reference model.
module tb_function_request_controller;
    import frc_pkg::*;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst, b1, b2, done;
    logic [1:0] f01, f02;
    logic       ie01_active, ie02_active, A, B, priorsel;
    logic [1:0] ie01_code, ie02_code;

    int checks = 0;
    int errors = 0;

    function_request_controller #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .ie01_btn(b1), .ie02_btn(b2),
        .ie01_func(f01), .ie02_func(f02), .done(done),
        .ie01_active(ie01_active), .ie02_active(ie02_active),
        .ie01_code(ie01_code), .ie02_code(ie02_code),
        .A(A), .B(B), .priorsel(priorsel)
    );

    always #5 clk = ~clk;

    // Reference model: raw and synchronized sample histories since the last reset.
    bit         hist [2][$];
    bit         sh   [2][$];
    bit         mdb  [2];
    bit         marm [2];
    bit         rpend[2];
    bit         mact [2];
    logic [1:0] mcode[2];
    bit         mps;

    function automatic bit last_d_equal(int i, bit v);
        int sz;
        sz = sh[i].size();
        if (sz < D) return 1'b0;
        for (int k = 0; k < D; k++)
            if (sh[i][sz-1-k] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge();
        bit   raw[2];
        bit   pr[2];
        bit   own[2];
        bit   ma, mb, s;
        int   n;
        logic [1:0] fn[2];
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                hist[i].delete(); sh[i].delete();
                mdb[i] = 0; marm[i] = 0; rpend[i] = 0; mact[i] = 0; mcode[i] = 2'd0;
            end
            mps = 0;
            return;
        end
        raw[0] = b1; raw[1] = b2; fn[0] = f01; fn[1] = f02;
        ma = mact[0] && mcode[0] == 2'd2;
        mb = mact[1] && mcode[1] == 2'd2;
        own[0] = ma ? (!mps || !mb) : (!mb && mact[0]);
        own[1] = mact[1] && !own[0];
        for (int i = 0; i < 2; i++) begin
            pr[i] = rpend[i];
            hist[i].push_back(raw[i]);
            n = hist[i].size();
            s = (n >= 3) ? hist[i][n-3] : 1'b0;
            sh[i].push_back(s);
            if (n >= 3 && !s && !mdb[i]) marm[i] = 1;
            rpend[i] = 0;
            if (last_d_equal(i, !mdb[i])) begin
                mdb[i]   = !mdb[i];
                rpend[i] = mdb[i] && marm[i];
            end
            if (done && own[i]) begin
                mact[i] = 0; mcode[i] = 2'd0;
            end else if (pr[i]) begin
                mact[i]  = !mact[i];
                mcode[i] = mact[i] ? fn[i] : 2'd0;
            end
        end
        if (done && ma && mb) mps = !mps;
    endtask

    task automatic chk(string tag, logic [1:0] obs, logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("ie01_active", {1'b0, ie01_active}, {1'b0, mact[0]});
        chk("ie02_active", {1'b0, ie02_active}, {1'b0, mact[1]});
        chk("ie01_code", ie01_code, mcode[0]);
        chk("ie02_code", ie02_code, mcode[1]);
        chk("A", {1'b0, A}, {1'b0, mact[0] && mcode[0] == 2'd2});
        chk("B", {1'b0, B}, {1'b0, mact[1] && mcode[1] == 2'd2});
        chk("priorsel", {1'b0, priorsel}, {1'b0, mps});
    endtask

    task automatic steps(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(int i, logic [1:0] fn);
        if (i == 0) begin f01 = fn; b1 = 1; end else begin f02 = fn; b2 = 1; end
        steps(D + 6);
        if (i == 0) b1 = 0; else b2 = 0;
        steps(D + 6);
    endtask

    task automatic pulse_done();
        done = 1; step(); done = 0;
    endtask

    int hold[2];
    bit lvl[2];

    initial begin
        rst = 1; b1 = 0; b2 = 0; done = 0; f01 = 0; f02 = 0;
        steps(3);
        chk("rst_active", {ie02_active, ie01_active}, 2'b00);
        chk("rst_ps", {1'b0, priorsel}, 2'd0);
        rst = 0;
        steps(4);

        // Clean press latency
        f01 = 2; b1 = 1;
        for (int k = 1; k <= D + 3; k++) begin
            step();
            if (k == D + 2) chk("lat_early", {1'b0, ie01_active}, 2'd0);
        end
        chk("lat_active", {1'b0, ie01_active}, 2'd1);
        chk("lat_code", ie01_code, 2'd2);
        chk("lat_A", {B, A}, 2'b01);
        chk("lat_ps", {1'b0, priorsel}, 2'd0);
        b1 = 0; steps(10);
        press(0, 2'd3);
        chk("cancel", {1'b0, ie01_active}, 2'd0);

        // Bouncing button never qualifies
        for (int k = 0; k < 20; k++) begin
            b2 = ((k / 2) % 2) == 0;
            step();
        end
        b2 = 0; steps(10);
        chk("bounce", {1'b0, ie02_active}, 2'd0);

        // Both function 2: done clears IE01 and toggles priority
        press(0, 2'd2);
        press(1, 2'd2);
        chk("both_f2", {B, A}, 2'b11);
        pulse_done();
        chk("done_both_ab", {B, A}, 2'b10);
        chk("done_both_ps", {1'b0, priorsel}, 2'd1);

        rst = 1; step(); rst = 0; steps(4);
        press(0, 2'd1);
        press(1, 2'd2);
        pulse_done();
        chk("done_b_act", {ie02_active, ie01_active}, 2'b01);
        chk("done_b_ps", {1'b0, priorsel}, 2'd0);
        chk("done_b_code1", ie01_code, 2'd1);

        // Press and done on the owner in the same cycle
        f01 = 2; b1 = 1;
        steps(D + 2);
        pulse_done();
        chk("done_press_act", {1'b0, ie01_active}, 2'd0);
        chk("done_press_code", ie01_code, 2'd0);
        b1 = 0; steps(10);
        chk("no_relatch", {1'b0, ie01_active}, 2'd0);

        // Reset with IE02 active and its button still held
        f02 = 3; b2 = 1; steps(D + 6);
        chk("held_act", {1'b0, ie02_active}, 2'd1);
        rst = 1; step(); rst = 0;
        chk("held_rst", {ie02_active, ie01_active, A, B}, 2'b00);
        steps(20);
        chk("held_quiet", {1'b0, ie02_active}, 2'd0);
        b2 = 0; steps(10);
        b2 = 1; steps(D + 6);
        chk("held_repress", {1'b0, ie02_active}, 2'd1);
        b2 = 0; steps(10);

        // Randomized traffic
        hold[0] = 0; hold[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++) begin
                if (hold[i] == 0) begin
                    lvl[i]  = 1'($urandom_range(0, 1));
                    hold[i] = $urandom_range(1, 2 * D + 3);
                end
                hold[i]--;
            end
            b1   = lvl[0];
            b2   = lvl[1];
            f01  = 2'($urandom_range(0, 3));
            f02  = 2'($urandom_range(0, 3));
            done = ($urandom_range(0, 5) == 0);
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
